planet_regfile: RTL
===================

Name: planet_regfile

Overview:
- Responder for the physics FSM's 6-lane register-file protocol (FSM_re/FSM_we, ADDR1..6, DATA1..6 out, DATA1in..6in in).
- Holds the 114-word simulation state: G, planet count, START/DONE, and 11 per-planet vectors of 10 planets.
- Also exposes a single-port host (Avalon-MM slave) so software loads planets, starts a step and polls DONE.

Parameters:
DEPTH, 114, number of 32-bit words (indices 0..113)
ACC_BASE, 84, first acceleration word (ACC_X/Y/Z occupy 84..113)
ACC_WORDS, 30, words cleared by clear_accs

Ports:
CLK  in  1  clock
RESET_N  in  1  asynchronous, active-low reset
FSM_re  in  2  bit0: read lanes 1-3, bit1: read lanes 4-6
FSM_we  in  2  bit0: write lanes 1-3, bit1: write lanes 4-6
ADDR1..ADDR6  in  32 each  lane word addresses
DATA1..DATA6  in  32 each  FSM write data
DATA1in..DATA6in  out  32 each  read data to FSM
clear_accs  in  1  zero acceleration words
FSM_DONE  in  1  FSM step complete
FSM_START  out  1  level of word 2 bit0
G  out  32  word 0
PLANET_NUM  out  32  word 1
AVL_CS, AVL_READ, AVL_WRITE  in  1 each  host strobes
AVL_ADDR  in  7  host word address
AVL_WRITEDATA  in  32  host write data
AVL_READDATA  out  32  host read data

Behaviour:
- Reset (async assert, sync release):
  - All words = 0; DATAxin = 0; AVL_READDATA = 0.
  - FSM_START = 0; G = 0; PLANET_NUM = 0.
- Word map:
  - 0 G; 1 PLANET_NUM; 2 START; 3 DONE.
  - Per-vector base b, planet i (1..10) at b+i: MASS b=3, RAD 13, POS_X 23, POS_Y 33, POS_Z 43, VEL_X 53, VEL_Y 63, VEL_Z 73, ACC_X 83, ACC_Y 93, ACC_Z 103.
- FSM reads:
  - Registered, latency 1: FSM_re[0] at edge N updates DATA1in..3in with words ADDR1..3 after edge N; FSM_re[1] likewise for DATA4in..6in.
  - Lanes not enabled hold their previous value.
  - Reads return pre-write (old) data when the same address is written in the same cycle.
- FSM writes:
  - FSM_we[0] writes DATA1..3 to ADDR1..3; FSM_we[1] writes DATA4..6 to ADDR4..6; all at the clock edge.
  - Lane collision on the same address: the highest-numbered lane wins.
- Out of range (addr >= DEPTH): reads return 0; writes dropped; no other effect.
- clear_accs:
  - At the edge, words 84..113 become 0.
  - Overrides any FSM/host write to those words in the same cycle.
- Host reads:
  - AVL_CS & AVL_READ registers word[AVL_ADDR] into AVL_READDATA after one edge.
  - AVL_ADDR >= DEPTH returns 0. AVL_READDATA holds otherwise.
- Host writes (AVL_CS & AVL_WRITE):
  - Writing word 2: START = WRITEDATA[0]; START=1 also clears DONE.
  - Writing word 3: ignored (DONE is read-only).
  - Other words are written only while START=0. While START=1 they are dropped (FSM owns the state).
- Host vs FSM priority:
  - FSM writes beat host writes on the same address in the same cycle.
  - The host port never stalls.
- DONE:
  - Set to 1 on any cycle with FSM_DONE=1 and START=1. Sticky.
  - Cleared only by a host write of START=1 or by reset.
  - FSM_DONE while START=0 is ignored.
- FSM_START, G and PLANET_NUM are combinational views of words 2[0], 0 and 1.
- Reset mid-transaction:
  - All state is lost immediately.
  - Pending read data is not delivered; outputs go to 0 asynchronously.

Test Plan:
- Reset, then host writes word0=0x40800000, word1=2, word23+1=0x3F800000 → G=0x40800000, PLANET_NUM=2; host read of 24 returns 0x3F800000 one cycle later.
- FSM_re=1, ADDR1/2/3=24/0/1 → next cycle DATA1in/2in/3in = 0x3F800000/0x40800000/2; DATA4..6in unchanged. FSM_re=3 with ADDR4..6 = 200/1/24 → DATA4in=0, DATA5in=2, DATA6in=0x3F800000.
- FSM_we=3, ADDR1=ADDR6=54, DATA1=0x11, DATA6=0x66, same-cycle FSM_re=1 on 54 → DATA1in = old value; subsequent read = 0x66.
- Host writes START=1; host write to word 25 while START=1 is dropped. FSM_DONE pulse → host read word3=1. Host writes START=0, then START=1 → DONE reads 0 and FSM_START=1.
- Preload words 84..113 with 0xBF800000; assert clear_accs with FSM_we=1, ADDR1=90 → all 30 words read 0, word 83 unchanged.
- Assert RESET_N=0 mid-read with FSM_re=3 → DATA1in..6in=0 and FSM_START=0 immediately; word 24 reads 0 after release.

Source files
------------

// File: rtl/planet_regfile.sv
// planet_regfile
//   Register file for one simulation step of the planet physics engine.
//   It holds 114 32-bit words and has two access paths:
//     - six FSM lanes, in two groups of three (lanes 1-3 and lanes 4-6)
//     - one Avalon-MM host port
//
// Word map:
//   0        G
//   1        PLANET_NUM
//   2        START (only bit 0 is stored)
//   3        DONE  (read-only for the host)
//   b+i      per-planet vectors, planet i = 1..10, with base b:
//              MASS 3, RAD 13, POS 23/33/43, VEL 53/63/73, ACC 83/93/103
//
// Ports:
//   CLK, RESET_N             clock; asynchronous active-low reset
//   FSM_re, FSM_we [1:0]     bit0 enables lanes 1-3, bit1 enables lanes 4-6
//   ADDR1..6, DATA1..6       lane word address and write data
//   DATA1in..6in             registered read data back to the FSM
//   clear_accs               zero the acceleration words (84..113)
//   FSM_DONE                 FSM reports that the step is complete
//   FSM_START, G, PLANET_NUM combinational views of words 2[0], 0 and 1
//   AVL_*                    host slave port; reads have one cycle latency
module planet_regfile #(
  parameter int DEPTH     = 114,
  parameter int ACC_BASE  = 84,
  parameter int ACC_WORDS = 30
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [1:0]  FSM_re,
  input  logic [1:0]  FSM_we,
  input  logic [31:0] ADDR1,
  input  logic [31:0] ADDR2,
  input  logic [31:0] ADDR3,
  input  logic [31:0] ADDR4,
  input  logic [31:0] ADDR5,
  input  logic [31:0] ADDR6,
  input  logic [31:0] DATA1,
  input  logic [31:0] DATA2,
  input  logic [31:0] DATA3,
  input  logic [31:0] DATA4,
  input  logic [31:0] DATA5,
  input  logic [31:0] DATA6,
  output logic [31:0] DATA1in,
  output logic [31:0] DATA2in,
  output logic [31:0] DATA3in,
  output logic [31:0] DATA4in,
  output logic [31:0] DATA5in,
  output logic [31:0] DATA6in,
  input  logic        clear_accs,
  input  logic        FSM_DONE,
  output logic        FSM_START,
  output logic [31:0] G,
  output logic [31:0] PLANET_NUM,
  input  logic        AVL_CS,
  input  logic        AVL_READ,
  input  logic        AVL_WRITE,
  input  logic [6:0]  AVL_ADDR,
  input  logic [31:0] AVL_WRITEDATA,
  output logic [31:0] AVL_READDATA
);

  localparam int              AW      = 7;
  localparam logic [AW-1:0]   DEPTH_A = AW'(DEPTH);
  localparam logic [31:0]     DEPTH_W = 32'(DEPTH);
  localparam logic [AW-1:0]   W_START = 7'd2;
  localparam logic [AW-1:0]   W_DONE  = 7'd3;

  logic [31:0] mem [DEPTH];
  logic [31:0] lane_addr [6];
  logic [31:0] lane_data [6];
  logic [5:0]  lane_we;
  logic        start;
  logic        host_wr;

  assign lane_addr[0] = ADDR1;
  assign lane_addr[1] = ADDR2;
  assign lane_addr[2] = ADDR3;
  assign lane_addr[3] = ADDR4;
  assign lane_addr[4] = ADDR5;
  assign lane_addr[5] = ADDR6;
  assign lane_data[0] = DATA1;
  assign lane_data[1] = DATA2;
  assign lane_data[2] = DATA3;
  assign lane_data[3] = DATA4;
  assign lane_data[4] = DATA5;
  assign lane_data[5] = DATA6;
  assign lane_we      = {{3{FSM_we[1]}}, {3{FSM_we[0]}}};

  assign start      = mem[2][0];
  assign FSM_START  = start;
  assign G          = mem[0];
  assign PLANET_NUM = mem[1];
  assign host_wr    = AVL_CS && AVL_WRITE && (AVL_ADDR < DEPTH_A);

  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a < DEPTH_W) ? mem[a[AW-1:0]] : 32'd0;
  endfunction

  // Write priority is set by statement order, so later statements win:
  //   host, then FSM lanes 1..6 (the highest lane wins), then clear_accs.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (FSM_DONE && start) mem[3] <= 32'd1;
      if (host_wr) begin
        if (AVL_ADDR == W_START) begin
          mem[2] <= {31'd0, AVL_WRITEDATA[0]};
          if (AVL_WRITEDATA[0]) mem[3] <= '0;
        end else if (AVL_ADDR != W_DONE && !start) begin
          mem[AVL_ADDR] <= AVL_WRITEDATA;
        end
      end
      for (int k = 0; k < 6; k++) begin
        if (lane_we[k] && (lane_addr[k] < DEPTH_W))
          mem[lane_addr[k][AW-1:0]] <= lane_data[k];
      end
      if (clear_accs) begin
        for (int i = ACC_BASE; i < ACC_BASE + ACC_WORDS; i++) mem[i] <= '0;
      end
    end
  end

  // Reads sample the array before this edge's writes land, so a read and a
  // write to the same word in one cycle return the old value.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      DATA1in      <= '0;
      DATA2in      <= '0;
      DATA3in      <= '0;
      DATA4in      <= '0;
      DATA5in      <= '0;
      DATA6in      <= '0;
      AVL_READDATA <= '0;
    end else begin
      if (FSM_re[0]) begin
        DATA1in <= rd(ADDR1);
        DATA2in <= rd(ADDR2);
        DATA3in <= rd(ADDR3);
      end
      if (FSM_re[1]) begin
        DATA4in <= rd(ADDR4);
        DATA5in <= rd(ADDR5);
        DATA6in <= rd(ADDR6);
      end
      if (AVL_CS && AVL_READ)
        AVL_READDATA <= (AVL_ADDR < DEPTH_A) ? mem[AVL_ADDR] : 32'd0;
    end
  end

endmodule
